// File: rtl/uart_rx_wb_if.sv
// Wishbone B3 classic bus bundle between a master (CPU/debug) and the UART receiver readout.
interface uart_rx_wb_if;
  logic [1:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave  (input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
                  output wb_dat_o, wb_ack_o);
  modport master (output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
                  input  wb_dat_o, wb_ack_o);
endinterface

// File: rtl/uart_rx_wb.sv
// 8N1 serial receiver feeding a small FIFO, read out through a Wishbone classic slave
// with RXDATA/STATUS/CTRL registers and a level interrupt.
module uart_rx_wb #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        rx_i,
  uart_rx_wb_if.slave wb,
  output logic        irq_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(CLK_DIV);
  localparam logic [TW-1:0]      T_HALF = TW'(CLK_DIV/2 - 1);
  localparam logic [TW-1:0]      T_FULL = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]      T_ONE  = TW'(1);
  localparam logic [FIFO_AW:0]   C_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   C_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] P_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state, state_nx;
  logic               rx_s1, rx_s2, rx_d, fall;
  logic [TW-1:0]      timer;
  logic               tick;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               tmr_load, bit_clr, bit_shift, stop_ok, stop_bad;
  logic [TW-1:0]      tmr_val;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full, push, ovr_set;
  logic               overrun, frame_err, irq_en;

  logic               req, rd_pop, wr_ctrl;
  logic [31:0]        status, rdata;
  logic               unused_dat;

  // Synchroniser plus one more flop for falling-edge detection; all idle high.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end
  assign fall = rx_d & ~rx_s2;
  assign tick = (timer == '0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (fall) state_nx = S_START;
      S_START: if (tick) state_nx = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (tick && bit_idx == 3'd7) state_nx = S_STOP;
      S_STOP:  if (tick) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tmr_load  = 1'b0;
    tmr_val   = T_FULL;
    bit_clr   = 1'b0;
    bit_shift = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE:  if (fall) begin tmr_load = 1'b1; tmr_val = T_HALF; end
      S_START: if (tick && !rx_s2) begin tmr_load = 1'b1; bit_clr = 1'b1; end
      S_DATA:  if (tick) begin tmr_load = 1'b1; bit_shift = 1'b1; end
      S_STOP:  if (tick) begin stop_ok = rx_s2; stop_bad = ~rx_s2; end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (tmr_load)     timer <= tmr_val;
      else if (!tick)   timer <= timer - T_ONE;
      if (bit_clr)      bit_idx <= '0;
      else if (bit_shift) begin
        shreg[bit_idx] <= rx_s2;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign empty   = (count == '0);
  assign full    = (count == C_FULL);
  assign push    = stop_ok & (~full | rd_pop);
  assign ovr_set = stop_ok & full & ~rd_pop;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + P_ONE;
      if (rd_pop) rd_ptr <= rd_ptr + P_ONE;
      case ({push, rd_pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: ;
      endcase
    end
  end

  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign rd_pop  = req & ~wb.wb_we_i & (wb.wb_adr_i == 2'd0) & ~empty;
  assign wr_ctrl = req & wb.wb_we_i & (wb.wb_adr_i == 2'd2);
  assign unused_dat = ^wb.wb_dat_i[31:3];

  always_comb begin
    status                 = '0;
    status[0]              = ~empty;
    status[1]              = full;
    status[2]              = overrun;
    status[3]              = frame_err;
    status[8+FIFO_AW:8]    = count;
  end

  always_comb begin
    rdata = '0;
    case (wb.wb_adr_i)
      2'd0:    if (!empty) rdata = {24'h0, mem[rd_ptr]};
      2'd1:    rdata = status;
      2'd2:    rdata = {31'h0, irq_en};
      default: ;
    endcase
  end

  // Sticky flags: a set in the same cycle as a CTRL clear wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      irq_en      <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      wb.wb_ack_o <= req;
      wb.wb_dat_o <= (req && !wb.wb_we_i) ? rdata : '0;
      overrun     <= ovr_set  | (overrun   & ~(wr_ctrl & wb.wb_dat_i[1]));
      frame_err   <= stop_bad | (frame_err & ~(wr_ctrl & wb.wb_dat_i[2]));
      if (wr_ctrl) irq_en <= wb.wb_dat_i[0];
      irq_o       <= irq_en & (~empty | overrun | frame_err);
    end
  end
endmodule

// File: tb/tb_uart_rx_wb.sv
// Scoreboard bench for uart_rx_wb: serial frames in, Wishbone reads out.
module tb_uart_rx_wb;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic irq;
  uart_rx_wb_if wb_bus();

  uart_rx_wb #(.CLK_DIV(DIV), .FIFO_AW(3)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .rx_i     (rx),
    .wb       (wb_bus),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic       exp_ovr = 1'b0;
  logic       exp_fe  = 1'b0;
  logic       irq_at_ack;
  logic [31:0] d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int n;
    n     = sb.size();
    s     = '0;
    s[0]  = (n != 0);
    s[1]  = (n == 8);
    s[2]  = exp_ovr;
    s[3]  = exp_fe;
    s[11:8] = 4'(n);
    return s;
  endfunction

  task automatic bus(input logic [1:0] adr, input logic we, input logic [31:0] wd,
                     output logic [31:0] rd);
    wb_bus.wb_adr_i = adr;
    wb_bus.wb_we_i  = we;
    wb_bus.wb_dat_i = wd;
    wb_bus.wb_cyc_i = 1'b1;
    wb_bus.wb_stb_i = 1'b1;
    tick(1);
    rd         = wb_bus.wb_dat_o;
    irq_at_ack = irq;
    chk("ack_rise", 32'(wb_bus.wb_ack_o), 32'd1);
    wb_bus.wb_cyc_i = 1'b0;
    wb_bus.wb_stb_i = 1'b0;
    wb_bus.wb_we_i  = 1'b0;
    tick(1);
    chk("ack_width", 32'(wb_bus.wb_ack_o), 32'd0);
    chk("dat_idle", wb_bus.wb_dat_o, 32'd0);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] got, exp;
    bus(2'd0, 1'b0, 32'd0, got);
    exp = (sb.size() > 0) ? {24'h0, sb.pop_front()} : 32'd0;
    chk(tag, got, exp);
  endtask

  task automatic rd_status(input string tag);
    logic [31:0] got, exp;
    exp = model_status();
    bus(2'd1, 1'b0, 32'd0, got);
    chk(tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    rx = stop;
    tick(DIV);
    rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rx = 1'b1;
    rst = 1'b1;
    wb_bus.wb_adr_i = '0;
    wb_bus.wb_dat_i = '0;
    wb_bus.wb_we_i  = 1'b0;
    wb_bus.wb_cyc_i = 1'b0;
    wb_bus.wb_stb_i = 1'b0;
    tick(3);
    chk("rst_ack", 32'(wb_bus.wb_ack_o), 32'd0);
    chk("rst_dat", wb_bus.wb_dat_o, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    tick(2);
    rd_status("rst_status");

    // single byte
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1);
    tick(2);
    chk("t1_model", model_status(), 32'h101);
    rd_status("t1_status_pre");
    rd_data("t1_rxdata");
    rd_status("t1_status_post");

    // glitch rejection
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    rd_status("t2_glitch_status");
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1);
    tick(2);
    rd_data("t2_rxdata");

    // framing error, clear, then clear colliding with a new error
    send(8'h55, 1'b0);
    exp_fe = 1'b1;
    tick(2);
    rd_status("t3_ferr");
    bus(2'd2, 1'b1, 32'h4, d);
    exp_fe = 1'b0;
    rd_status("t3_cleared");
    fork
      send(8'h55, 1'b0);
      begin tick(154); bus(2'd2, 1'b1, 32'h4, d); end
    join
    exp_fe = 1'b1;
    tick(2);
    rd_status("t3_set_wins");
    bus(2'd2, 1'b1, 32'h4, d);
    exp_fe = 1'b0;
    rd_status("t3_cleared2");

    // fill and overrun
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back(8'(i));
      send(8'(i), 1'b1);
    end
    exp_ovr = 1'b1;
    tick(2);
    chk("t4_model", model_status(), 32'h807);
    rd_status("t4_full_ovr");
    for (int i = 0; i < 8; i++) rd_data("t4_drain");
    rd_data("t4_empty_read");
    rd_status("t4_ovr_only");
    bus(2'd2, 1'b1, 32'h2, d);
    exp_ovr = 1'b0;
    rd_status("t4_ovr_clear");

    // refill, then push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'(8'h20 + i));
      send(8'(8'h20 + i), 1'b1);
    end
    fork
      begin sb.push_back(8'h28); send(8'h28, 1'b1); end
      begin tick(154); rd_data("t4_pushpop"); end
    join
    tick(2);
    rd_status("t4_full_no_ovr");
    while (sb.size() > 0) rd_data("t4_wrap_drain");
    for (int i = 0; i < 11; i++) begin
      sb.push_back(8'(8'h30 + 7 * i));
      send(8'(8'h30 + 7 * i), 1'b1);
      if (i % 3 == 2 || i == 10) begin
        tick(2);
        rd_status("t4_wrap_status");
        while (sb.size() > 0) rd_data("t4_wrap_rd");
      end
    end
    rd_status("t4_final");

    // interrupt
    sb.push_back(8'h11);
    send(8'h11, 1'b1);
    tick(3);
    chk("t5_irq_dis", 32'(irq), 32'd0);
    bus(2'd2, 1'b1, 32'h1, d);
    chk("t5_irq_at_wr", 32'(irq_at_ack), 32'd0);
    chk("t5_irq_on", 32'(irq), 32'd1);
    rd_data("t5_rxdata");
    chk("t5_irq_at_pop", 32'(irq_at_ack), 32'd1);
    chk("t5_irq_off", 32'(irq), 32'd0);

    // reset mid-frame with a byte pending and irq asserted
    sb.push_back(8'h77);
    send(8'h77, 1'b1);
    tick(3);
    chk("t6_irq_pre", 32'(irq), 32'd1);
    fork
      send(8'hF0, 1'b1);
      begin
        tick(85);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_rst_ack", 32'(wb_bus.wb_ack_o), 32'd0);
        chk("t6_rst_dat", wb_bus.wb_dat_o, 32'd0);
        chk("t6_rst_irq", 32'(irq), 32'd0);
      end
    join
    sb.delete();
    tick(5);
    rd_status("t6_status");
    bus(2'd2, 1'b0, 32'd0, d);
    chk("t6_ctrl_rst", d, 32'd0);
    sb.push_back(8'h81);
    send(8'h81, 1'b1);
    tick(3);
    chk("t6_irq_still_off", 32'(irq), 32'd0);
    rd_status("t6_status_81");
    rd_data("t6_rxdata");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_wb.md
# uart_rx_wb

Serial 8N1 receiver with a Wishbone B3 classic slave readout. It sits at the far end of a uart16550 `stx_pad_o` line in the simulation SoC. It deserialises the bytes the CPU transmits, buffers them in a small FIFO, and exposes them to a Wishbone master (CPU or debug master) through a register interface with an interrupt. It closes the loop for UART self-test software without a host terminal.

## Interface
- `CLK_DIV`, 16: clock cycles per bit period. Must be even and ≥ 4.
- `FIFO_AW`, 3: FIFO address width. Depth is 2^FIFO_AW entries (8).
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `rx_i` in 1: serial input, asynchronous, idle high.
- `wb_adr_i` in 2: word register select.
- `wb_dat_i` in 32: write data.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_dat_o` in the output direction, 32 bits: read data, valid only while `wb_ack_o` is high, 0 otherwise.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `irq_o` out 1: level interrupt, registered.

## Operation
Registers:
- **RXDATA (adr 0):**
  - Read returns {24'h0, byte} and pops the FIFO.
  - Read while the FIFO is empty returns 0 and does not pop.
  - Write is ignored.
- **STATUS (adr 1), read-only:**
  - bit0 = data_avail (FIFO not empty).
  - bit1 = full.
  - bit2 = overrun.
  - bit3 = frame_err.
  - bits[8+FIFO_AW:8] = fill count.
  - All other bits 0.
- **CTRL (adr 2):**
  - bit0 = irq_en, read/write.
  - Writing 1 to bit1 clears overrun.
  - Writing 1 to bit2 clears frame_err.
  - Reads return {31'h0, irq_en}.
- **adr 3:** reads 0, writes ignored.

Receiver path:
- `rx_i` passes through a 2-flop synchroniser; both flops reset to 1. A falling edge is detected on the synchronised signal.
- The FSM is IDLE → START → DATA → STOP → IDLE, with a bit-timer counter of width clog2(CLK_DIV) and a 3-bit bit index.
- **IDLE:** on a falling edge, load the timer with CLK_DIV/2−1 and go to START.
- **START:** when the timer reaches 0, sample the line.
  - Sample 0: reload the timer with CLK_DIV−1, set the bit index to 0, go to DATA.
  - Sample 1 (glitch): return to IDLE. No flag is set.
- **DATA:** at each timer expiry, shift the sample into bit[index] (LSB first) and reload the timer. After index 7, go to STOP.
- **STOP:** at timer expiry, sample the line.
  - Sample 1 and FIFO not full: push the byte.
  - Sample 1 and FIFO full: drop the byte and set overrun.
  - Sample 0: drop the byte and set frame_err.
  - In all cases return to IDLE. A new start bit is accepted only after a fresh falling edge.
- overrun and frame_err are sticky until cleared through CTRL.
- `irq_o` is registered: irq_en & (data_avail | overrun | frame_err).

## Timing
Reset values:
- `wb_ack_o` = 0, `wb_dat_o` = 0, `irq_o` = 0.
- FSM = IDLE.
- FIFO empty with count 0; pointers 0.
- overrun = 0, frame_err = 0, irq_en = 0.
- Synchroniser = 1.

Reset asserted mid-frame or mid-bus-cycle aborts everything to these values on the next edge. The partially received byte is lost.

Wishbone handshake:
- A request is `wb_cyc_i & wb_stb_i & !wb_ack_o`.
- `wb_ack_o` rises the cycle after the request and stays high for exactly 1 cycle. Back-to-back requests therefore see an ack every other cycle.
- Register write effects and the RXDATA pop take effect on the ack edge.
- No err or rty responses are generated.

Receive timing:
- Latency from `rx_i` transition to the synchronised signal: 2 cycles.
- The mid-bit sample falls CLK_DIV/2 cycles after the synchronised falling edge, then every CLK_DIV cycles after that.
- A pushed byte is visible (data_avail = 1, count incremented) the cycle after the stop-bit sample.
- `irq_o` follows one cycle later.

Boundary and simultaneous events:
- **Push and pop in the same cycle:** both happen and the count is unchanged. If the FIFO was full, the push succeeds because the pop frees a slot, so no overrun is set.
- **Pop while empty:** no pointer movement and the count stays 0.
- **Push while full with no simultaneous pop:** overrun is set and FIFO contents are untouched.
- **Flag set and CTRL clear in the same cycle:** the set wins.
- **Wrap-around:** pointers wrap modulo 2^FIFO_AW. The count is a separate FIFO_AW+1-bit register, range 0 to 2^FIFO_AW.

## Test plan
All scenarios use CLK_DIV=16 and FIFO_AW=3.
- **Single byte:** drive 0xA5 in 8N1 at 16 cycles/bit, then read RXDATA.
  - STATUS reads 0x101 before the RXDATA read.
  - RXDATA returns 0x000000A5.
  - STATUS reads 0x000 afterwards.
  - Every access's ack is 1 cycle wide, 1 cycle after stb.
- **Glitch rejection:** drive `rx_i` low for 4 cycles, then high.
  - No byte is pushed.
  - STATUS reads 0.
  - A following valid 0x3C is received correctly.
- **Framing error:** send 0x55 with the stop bit driven 0.
  - STATUS bit3 = 1 and the count stays 0.
  - A CTRL write of 0x4 clears it.
  - A 0x4 written together with a new frame error in the same cycle leaves bit3 = 1.
- **Fill and overrun:**
  - Send 9 bytes 0x00..0x08 with no reads.
  - STATUS reads full and count 8 with overrun = 1.
  - Eight RXDATA reads return 0x00..0x07 in order.
  - Repeat pushing and popping 20 more bytes to verify pointer wrap.
- **Interrupt:**
  - With irq_en = 0, receive 0x11: `irq_o` stays 0.
  - Write CTRL = 1: `irq_o` = 1 two cycles later.
  - Read RXDATA: `irq_o` falls the cycle after the FIFO becomes empty.
- **Reset mid-frame:**
  - Assert `wb_rst_i` for 1 cycle during bit 4 of 0xF0.
  - All outputs return to reset values.
  - The remainder of the frame produces no push, or at most a frame error if its trailing bits form a falling edge.
  - The next clean byte 0x81 is received correctly.
